// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output channels of inst_encoder.
// master drives bundles and consumes words; slave is the encoder.
interface inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid,
        output in_class,
        output in_rd,
        output in_rs1,
        output in_rs2,
        output in_funct3,
        output in_funct7,
        output in_imm,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_inst,
        input  out_addr,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_class,
        input  in_rd,
        input  in_rs1,
        input  in_rs2,
        input  in_funct3,
        input  in_funct7,
        input  in_imm,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_inst,
        output out_addr,
        output out_err
    );
endinterface

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: field bundles in, addressed machine words out.
// Define INST_ENC_RANGE_CHECK_EN to reject out-of-range immediates.
module inst_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    inst_encoder_if.slave  bus,
    output logic           done,
    output logic [7:0]     err_cnt
);

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [6:0]  OP_R = 7'b0110011;
    localparam logic [6:0]  OP_I = 7'b0010011;
    localparam logic [6:0]  OP_L = 7'b0000011;
    localparam logic [6:0]  OP_S = 7'b0100011;
    localparam logic [6:0]  OP_B = 7'b1100011;
    localparam logic [6:0]  OP_J = 7'b1101111;
    localparam logic [6:0]  OP_U = 7'b0110111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              out_valid_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [7:0]        err_cnt_q;

    logic              rdy;
    logic              accept;
    logic              out_hs;
    logic              load_base;

    logic [31:0]       imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [7:0]        cls_oh;
    logic              is_shift;
    logic [31:0]       raw_inst;
    logic              raw_bad;
    logic              rng_ok;
    logic [31:0]       enc_inst;
    logic              enc_err;

    assign imm      = bus.in_imm;
    assign rd       = bus.in_rd;
    assign rs1      = bus.in_rs1;
    assign rs2      = bus.in_rs2;
    assign f3       = bus.in_funct3;
    assign f7       = bus.in_funct7;
    assign cls_oh   = 8'd1 << bus.in_class;
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        raw_inst = NOP;
        raw_bad  = 1'b0;
        unique case (1'b1)
            cls_oh[0]: raw_inst = {f7, rs2, rs1, f3, rd, OP_R};
            cls_oh[1]: begin
                if (is_shift)
                    raw_inst = {f7, imm[4:0], rs1, f3, rd, OP_I};
                else
                    raw_inst = {imm[11:0], rs1, f3, rd, OP_I};
            end
            cls_oh[2]: raw_inst = {imm[11:0], rs1, f3, rd, OP_L};
            cls_oh[3]: raw_inst = {imm[11:5], rs2, rs1,
                                   f3, imm[4:0], OP_S};
            cls_oh[4]: raw_inst = {imm[12], imm[10:5], rs2, rs1,
                                   f3, imm[4:1], imm[11], OP_B};
            cls_oh[5]: raw_inst = {imm[20], imm[10:1], imm[11],
                                   imm[19:12], rd, OP_J};
            cls_oh[6]: raw_inst = {imm[31:12], rd, OP_U};
            cls_oh[7]: raw_bad  = 1'b1;
            default:   raw_bad  = 1'b1;
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    logic s12_ok;
    logic shamt_ok;
    logic b_ok;
    logic j_ok;
    logic lui_ok;

    // A value fits a signed N-bit field when bits [31:N-1] are all equal.
    assign s12_ok   = (&imm[31:11]) || !(|imm[31:11]);
    assign shamt_ok = !(|imm[31:5]);
    assign b_ok     = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
    assign j_ok     = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
    assign lui_ok   = !(|imm[11:0]);

    always_comb begin
        rng_ok = 1'b1;
        unique case (1'b1)
            cls_oh[1]: rng_ok = is_shift ? shamt_ok : s12_ok;
            cls_oh[2]: rng_ok = s12_ok;
            cls_oh[3]: rng_ok = s12_ok;
            cls_oh[4]: rng_ok = b_ok;
            cls_oh[5]: rng_ok = j_ok;
            cls_oh[6]: rng_ok = lui_ok;
            default:   rng_ok = 1'b1;
        endcase
    end
`else
    assign rng_ok = 1'b1;
`endif

    assign enc_err  = raw_bad || !rng_ok;
    assign enc_inst = enc_err ? NOP : raw_inst;

    assign accept    = bus.in_valid && rdy;
    assign out_hs    = out_valid_q && bus.out_ready;
    assign load_base = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = RUN;
            end
            RUN: begin
                rdy = !out_valid_q || bus.out_ready;
                if (bus.in_valid && rdy && bus.in_last)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (out_hs)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_base) begin
                addr_q    <= BASE_ADDR;
                err_cnt_q <= '0;
            end else begin
                // Address of the held word advances once it is taken.
                if (out_hs)
                    addr_q <= addr_q + 1'b1;
                if (accept && enc_err && (err_cnt_q != 8'hFF))
                    err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (accept) begin
                out_valid_q <= 1'b1;
                inst_q      <= enc_inst;
                err_q       <= enc_err;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = inst_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_err   = err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V RV32I instruction encoder: accepts decoded field bundles (instruction class, register indices, funct3/funct7, immediate) and assembles 32-bit machine words. Each word is tagged with a sequential instruction-memory word address. It is the inverse of the Controller decode path and sits in the bench/boot infrastructure, filling instruction memory before the single-cycle core runs. Range checking, backpressure and a start/done program-load sequence make it a small sequential block, not a lookup.

## Interface
- `ADDR_W`, 8: width of the instruction-memory word address.
- `BASE_ADDR`, 0: word address loaded into the address counter on `start`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a program load.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept the bundle.
- `in_class`  in  3  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 invalid.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3; `in_funct7`  in  7.
- `in_imm`  in  32  signed byte-offset or immediate value.
- `in_last`  in  1  marks the final bundle of the program.
- `out_valid`  out  1  `out_inst` and `out_addr` are valid.
- `out_ready`  in  1  the memory writer accepts the word.
- `out_inst`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  word address for `out_inst`.
- `out_err`  out  1  this word failed its encoding check.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `err_cnt`  out  8  saturating count of errored words in the current load.

## Operation
- FSM states:
  - IDLE: `in_ready`=0. `start` loads `BASE_ADDR`, clears `err_cnt`, and moves to RUN.
  - RUN: accept and emit bundles.
  - DRAIN: the last bundle was accepted; wait for its output handshake.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- Handshakes:
  - Input handshake: `in_valid && in_ready`.
  - In RUN, `in_ready = !out_valid || out_ready`.
  - Output handshake: `out_valid && out_ready`.
- Encoding (`op` = opcode):
  - R: {f7,rs2,rs1,f3,rd,0110011}.
  - I-ALU: {imm[11:0],rs1,f3,rd,0010011}.
  - I-ALU with f3=001/101: {f7,imm[4:0],rs1,f3,rd,0010011}.
  - LOAD: {imm[11:0],rs1,f3,rd,0000011}.
  - STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],0100011}.
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
  - LUI: {imm[31:12],rd,0110111}.
- Class 7 always errors: `out_inst`=32'h00000013 (NOP), `out_err`=1.
- On an errored word, `err_cnt` increments and saturates at 255.
- `out_addr` increments by 1 on each output handshake and wraps modulo 2^ADDR_W without error.
- `start` while not in IDLE is ignored.
- `in_valid` in IDLE/DRAIN/DONE is ignored, since `in_ready`=0.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_inst`=0, `out_addr`=`BASE_ADDR`, `out_err`=0, `done`=0, `err_cnt`=0, state IDLE.
- Latency: a bundle accepted at edge N appears on the outputs after edge N, with `out_valid`=1 in cycle N+1.
- Throughput: 1 word/cycle while `out_ready`=1.
- Backpressure:
  - With `out_valid`=1 and `out_ready`=0, `out_inst`/`out_addr`/`out_err` hold stable and `in_ready`=0.
  - When an output and input handshake occur in the same cycle, the register is replaced with no bubble.
- `in_last` accepted: `in_ready`=0 from the next cycle. `done` is asserted in the cycle after the last output handshake.
- An asynchronous `rst_n` assertion mid-load discards any pending word and returns all outputs to reset values immediately.

## Configuration
- `INST_ENC_RANGE_CHECK_EN` defined: the immediate range is checked per class. Any violation emits the NOP with `out_err`=1. Checks:
  - I/LOAD/STORE: signed 12-bit.
  - Shift: 0..31.
  - BRANCH: signed 13-bit and even.
  - JAL: signed 21-bit and even.
  - LUI: imm[11:0]=0.
- Undefined: no immediate checks; out-of-range bits are silently truncated. `out_err` is raised only for class 7.

## Test plan
- start; bundles (each with `out_ready`=1), `out_addr` 0,1,2, `done` pulse after the third:
  - R add x3,x1,x2 → 0x002081B3.
  - R sub (f7=0100000) → 0x402081B3.
  - I-ALU addi x2,x1,0x123 → 0x12308113.
- STORE sw x2,32(x1) → 0x0220A023. BRANCH beq x1,x2,+8 → 0x00208463. JAL x1,+2048 → 0x001000EF. LUI x1,0xABCDE000 → 0xABCDE0B7.
- addi imm=2048 with the macro → 0x00000013, `out_err`=1, `err_cnt`=1. The same bundle without the macro → 0x80008113, `out_err`=0.
- `out_ready` held 0 for 3 cycles with a word pending → outputs stable and `in_ready`=0. On release, back-to-back words arrive with no bubble.
- `ADDR_W`=2, `BASE_ADDR`=3: 3 words → `out_addr` 3,0,1. `rst_n` pulsed low mid-load → `out_valid`=0, state IDLE, `err_cnt`=0.
